// File: rtl/alu_share_arb.sv
// alu_share_arb: round-robin sharing of one combinational alu between two
// requesters, with a two-stage (operand / response) pipeline, illegal-opcode
// flagging and saturating per-requester grant counters.
module alu_share_arb #(
    parameter int unsigned OP_W   = 12,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TAG_W  = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              resetn,
    // request side
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [DATA_W-1:0] req0_src1,
    input  logic [DATA_W-1:0] req0_src2,
    input  logic [TAG_W-1:0]  req0_tag,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [DATA_W-1:0] req1_src1,
    input  logic [DATA_W-1:0] req1_src2,
    input  logic [TAG_W-1:0]  req1_tag,
    // shared alu
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_src1,
    output logic [DATA_W-1:0] alu_src2,
    input  logic [DATA_W-1:0] alu_result,
    // response side
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_err,
    // statistics
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  grant_cnt0,
    output logic [CNT_W-1:0]  grant_cnt1
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Payload held in S1 while the alu evaluates it.
    typedef struct packed {
        logic              id;
        logic [TAG_W-1:0]  tag;
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] src1;
        logic [DATA_W-1:0] src2;
    } s1_t;

    logic       s1_valid;
    s1_t        s1_q;
    s1_t        s1_d;
    logic       last_grant;
    logic       s2_free;
    logic       s1_adv;
    logic       s1_free;
    logic [1:0] grant;
    logic       accept;
    logic       acc_id;
    logic       s1_illegal;

    // Pipeline flow control: a stage is free when empty or draining this cycle.
    always_comb begin
        s2_free = !rsp_valid || rsp_ready;
        s1_adv  = s1_valid && s2_free;
        s1_free = !s1_valid || s1_adv;
    end

    // Round-robin grant: a lone requester wins; on a tie the one not served last wins.
    always_comb begin
        grant = 2'b00;
        if (req_valid == 2'b11) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end else begin
            grant = req_valid;
        end
        req_ready = s1_free ? grant : 2'b00;
        accept    = |(req_valid & req_ready);
        acc_id    = req_ready[1];
    end

    // Select the winning requester's payload for loading into S1.
    always_comb begin
        s1_d = '0;
        if (acc_id) begin
            s1_d.id   = 1'b1;
            s1_d.tag  = req1_tag;
            s1_d.op   = req1_op;
            s1_d.src1 = req1_src1;
            s1_d.src2 = req1_src2;
        end else begin
            s1_d.id   = 1'b0;
            s1_d.tag  = req0_tag;
            s1_d.op   = req0_op;
            s1_d.src1 = req0_src1;
            s1_d.src2 = req0_src2;
        end
    end

    // Arbitration history only moves when a request is actually taken.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= acc_id;
        end
    end

    // S1 operand stage.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_q     <= s1_d;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // Drive the alu only while S1 holds a live operation.
    always_comb begin
        alu_op   = s1_valid ? s1_q.op   : '0;
        alu_src1 = s1_valid ? s1_q.src1 : '0;
        alu_src2 = s1_valid ? s1_q.src2 : '0;
    end

    // Zero or multi-hot opcodes have no defined alu meaning.
    always_comb begin
        s1_illegal = !$onehot(s1_q.op);
    end

    // S2 response stage; held stable while the consumer stalls.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_tag    <= '0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
        end else if (s1_adv) begin
            rsp_valid  <= 1'b1;
            rsp_id     <= s1_q.id;
            rsp_tag    <= s1_q.tag;
            rsp_result <= s1_illegal ? '0 : alu_result;
            rsp_err    <= s1_illegal;
        end else if (rsp_ready) begin
            rsp_valid  <= 1'b0;
        end
    end

    // Saturating grant counters; clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else if (clr_cnt) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else if (accept) begin
            if (!acc_id && grant_cnt0 != CNT_MAX) begin
                grant_cnt0 <= grant_cnt0 + CNT_W'(1);
            end
            if (acc_id && grant_cnt1 != CNT_MAX) begin
                grant_cnt1 <= grant_cnt1 + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed self-checking bench for alu_share_arb with a small behavioural alu.
module tb_alu_share_arb;

    logic        clk;
    logic        resetn;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [11:0] req0_op;
    logic [31:0] req0_src1;
    logic [31:0] req0_src2;
    logic [3:0]  req0_tag;
    logic [11:0] req1_op;
    logic [31:0] req1_src1;
    logic [31:0] req1_src2;
    logic [3:0]  req1_tag;
    logic [11:0] alu_op;
    logic [31:0] alu_src1;
    logic [31:0] alu_src2;
    logic [31:0] alu_result;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [3:0]  rsp_tag;
    logic [31:0] rsp_result;
    logic        rsp_err;
    logic        clr_cnt;
    logic [15:0] grant_cnt0;
    logic [15:0] grant_cnt1;

    int vectors;
    int miscompares;

    alu_share_arb dut (
        .clk        (clk),
        .resetn     (resetn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req0_op    (req0_op),
        .req0_src1  (req0_src1),
        .req0_src2  (req0_src2),
        .req0_tag   (req0_tag),
        .req1_op    (req1_op),
        .req1_src1  (req1_src1),
        .req1_src2  (req1_src2),
        .req1_tag   (req1_tag),
        .alu_op     (alu_op),
        .alu_src1   (alu_src1),
        .alu_src2   (alu_src2),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_tag    (rsp_tag),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .clr_cnt    (clr_cnt),
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1)
    );

    // Behavioural alu; non-one-hot opcodes yield a garbage pattern.
    always_comb begin
        case (alu_op)
            12'h001: alu_result = alu_src1 + alu_src2;
            12'h002: alu_result = alu_src1 - alu_src2;
            12'h004: alu_result = alu_src1 & alu_src2;
            12'h008: alu_result = alu_src1 | alu_src2;
            12'h010: alu_result = alu_src1 ^ alu_src2;
            default: alu_result = 32'hBAD0_BAD0;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic set0(input logic [11:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] tag);
        req0_op = op; req0_src1 = a; req0_src2 = b; req0_tag = tag;
    endtask

    task automatic set1(input logic [11:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] tag);
        req1_op = op; req1_src1 = a; req1_src2 = b; req1_tag = tag;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        resetn      = 1'b0;
        req_valid   = 2'b00;
        rsp_ready   = 1'b1;
        clr_cnt     = 1'b0;
        set0(12'h000, 32'd0, 32'd0, 4'd0);
        set1(12'h000, 32'd0, 32'd0, 4'd0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_rsp_tag", 32'(rsp_tag), 32'd0);
        chk("rst_rsp_result", rsp_result, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'd0);
        chk("rst_cnt0", 32'(grant_cnt0), 32'd0);
        chk("rst_cnt1", 32'(grant_cnt1), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        tick();

        // Single add from req0: 5+7, tag 3
        set0(12'h001, 32'd5, 32'd7, 4'd3);
        req_valid = 2'b01;
        #1 chk("add_req_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = 2'b00;
        #1;
        chk("add_alu_op", 32'(alu_op), 32'h001);
        chk("add_alu_src1", alu_src1, 32'd5);
        chk("add_alu_src2", alu_src2, 32'd7);
        chk("add_rsp_early", 32'(rsp_valid), 32'd0);
        tick();
        chk("add_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("add_rsp_result", rsp_result, 32'd12);
        chk("add_rsp_id", 32'(rsp_id), 32'd0);
        chk("add_rsp_tag", 32'(rsp_tag), 32'd3);
        chk("add_rsp_err", 32'(rsp_err), 32'd0);
        chk("add_cnt0", 32'(grant_cnt0), 32'd1);
        tick();
        chk("add_rsp_drained", 32'(rsp_valid), 32'd0);

        // Multi-hot opcode from req1
        set1(12'h003, 32'd9, 32'd4, 4'd6);
        req_valid = 2'b10;
        #1 chk("ill_req_ready", 32'(req_ready), 32'd2);
        tick();
        req_valid = 2'b00;
        #1 chk("ill_alu_op", 32'(alu_op), 32'h003);
        tick();
        chk("ill_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("ill_rsp_err", 32'(rsp_err), 32'd1);
        chk("ill_rsp_result", rsp_result, 32'd0);
        chk("ill_rsp_id", 32'(rsp_id), 32'd1);
        chk("ill_rsp_tag", 32'(rsp_tag), 32'd6);
        chk("ill_cnt1", 32'(grant_cnt1), 32'd1);

        // Zero opcode from req0
        set0(12'h000, 32'd1, 32'd1, 4'd9);
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        tick();
        chk("zop_rsp_err", 32'(rsp_err), 32'd1);
        chk("zop_rsp_result", rsp_result, 32'd0);
        chk("zop_rsp_id", 32'(rsp_id), 32'd0);
        chk("zop_rsp_tag", 32'(rsp_tag), 32'd9);
        chk("zop_cnt0", 32'(grant_cnt0), 32'd2);
        tick();

        // Reset while S1 and S2 are both occupied
        set0(12'h001, 32'd1, 32'd1, 4'd1);
        req_valid = 2'b01;
        tick();
        tick();
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        #1;
        chk("prerst_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("prerst_alu_op", 32'(alu_op), 32'h001);
        #1 resetn = 1'b0;
        #1;
        chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("arst_alu_op", 32'(alu_op), 32'd0);
        chk("arst_cnt0", 32'(grant_cnt0), 32'd0);
        @(negedge clk);
        resetn    = 1'b1;
        rsp_ready = 1'b1;
        tick();
        chk("postrst_rsp_valid_a", 32'(rsp_valid), 32'd0);
        tick();
        chk("postrst_rsp_valid_b", 32'(rsp_valid), 32'd0);

        // Both requesters continuously valid: strict alternation starting with req0
        set0(12'h001, 32'd10, 32'd20, 4'd5);
        set1(12'h002, 32'd100, 32'd1, 4'd9);
        for (int k = 0; k < 10; k++) begin
            req_valid = (k < 8) ? 2'b11 : 2'b00;
            #1;
            if (k < 8) begin
                chk("alt_req_ready", 32'(req_ready), (k % 2 == 1) ? 32'd2 : 32'd1);
            end
            if (k >= 2) begin
                chk("alt_rsp_valid", 32'(rsp_valid), 32'd1);
                chk("alt_rsp_id", 32'(rsp_id), 32'((k - 2) % 2));
                chk("alt_rsp_result", rsp_result, ((k - 2) % 2 == 1) ? 32'd99 : 32'd30);
                chk("alt_rsp_tag", 32'(rsp_tag), ((k - 2) % 2 == 1) ? 32'd9 : 32'd5);
            end
            tick();
        end
        chk("alt_cnt0", 32'(grant_cnt0), 32'd4);
        chk("alt_cnt1", 32'(grant_cnt1), 32'd4);
        chk("alt_rsp_drained", 32'(rsp_valid), 32'd0);

        // Fill pipe then stall the response channel for 5 cycles
        set0(12'h001, 32'd1, 32'd2, 4'd1);
        req_valid = 2'b01;
        #1 chk("stl_rr_a", 32'(req_ready), 32'd1);
        tick();
        set1(12'h002, 32'd50, 32'd8, 4'd2);
        req_valid = 2'b10;
        #1 chk("stl_rr_b", 32'(req_ready), 32'd2);
        tick();
        set0(12'h001, 32'd3, 32'd4, 4'd3);
        req_valid = 2'b01;
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stl_rr_blocked", 32'(req_ready), 32'd0);
            chk("stl_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("stl_rsp_result", rsp_result, 32'd3);
            chk("stl_rsp_tag", 32'(rsp_tag), 32'd1);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        chk("stl_rr_resume", 32'(req_ready), 32'd1);
        chk("stl_rsp_a_result", rsp_result, 32'd3);
        chk("stl_rsp_a_id", 32'(rsp_id), 32'd0);
        tick();
        req_valid = 2'b00;
        #1;
        chk("stl_rsp_b_valid", 32'(rsp_valid), 32'd1);
        chk("stl_rsp_b_id", 32'(rsp_id), 32'd1);
        chk("stl_rsp_b_result", rsp_result, 32'd42);
        chk("stl_rsp_b_tag", 32'(rsp_tag), 32'd2);
        tick();
        chk("stl_rsp_c_valid", 32'(rsp_valid), 32'd1);
        chk("stl_rsp_c_id", 32'(rsp_id), 32'd0);
        chk("stl_rsp_c_result", rsp_result, 32'd7);
        chk("stl_rsp_c_tag", 32'(rsp_tag), 32'd3);
        tick();
        chk("stl_rsp_drained", 32'(rsp_valid), 32'd0);

        // Counter clear, saturation and clear-over-increment priority
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        chk("sat_clr_cnt0", 32'(grant_cnt0), 32'd0);
        chk("sat_clr_cnt1", 32'(grant_cnt1), 32'd0);
        set0(12'h001, 32'd0, 32'd0, 4'd0);
        req_valid = 2'b01;
        repeat (65535) @(posedge clk);
        #1;
        chk("sat_cnt0_max", 32'(grant_cnt0), 32'h0000_FFFF);
        chk("sat_cnt1_idle", 32'(grant_cnt1), 32'd0);
        tick();
        chk("sat_cnt0_hold", 32'(grant_cnt0), 32'h0000_FFFF);
        clr_cnt = 1'b1;
        #1 chk("sat_rr_during_clr", 32'(req_ready), 32'd1);
        tick();
        chk("sat_clr_priority", 32'(grant_cnt0), 32'd0);
        clr_cnt   = 1'b0;
        req_valid = 2'b00;
        tick();
        chk("sat_idle_hold", 32'(grant_cnt0), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
